drive_cmd_arbiter: RTL and testbench
====================================

DRIVE_CMD_ARBITER -- requirements
Module: drive_cmd_arbiter

Interface
REQ-001 Parameter MANUAL_HOLD, default 50_000_000, clk_50 cycles that manual control persists after the last IR command.
REQ-002 Parameter LOST_TIMEOUT, default 12_500_000, clk_50 cycles without orange_detected before TRACK falls back to SEARCH.
REQ-003 Parameter SEARCH_SPEED, default 2'd1, cmd_speed used while in SEARCH.
REQ-004 clk_50  in  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 ir_valid  in  1  one-cycle strobe; ir_button holds a new decoded IR code.
REQ-007 ir_button  in  8  IR code: 8'h01 FWD, 8'h02 LEFT, 8'h03 RIGHT, 8'h04 REV, 8'h05 STOP, 8'h0A AUTO; all other codes ignored.
REQ-008 cam_direction  in  3  camera steering request; sampled every cycle.
REQ-009 orange_detected  in  1  level; target visible this cycle.
REQ-010 speed  in  2  mic-derived speed level.
REQ-011 cmd_ready  in  1  motor driver accepts cmd when cmd_valid && cmd_ready.
REQ-012 cmd_valid  out  1  command offered.
REQ-013 cmd_dir  out  3  0 STOP, 1 FWD, 2 LEFT, 3 RIGHT, 4 REV, 5 SPIN.
REQ-014 cmd_speed  out  2  speed for cmd_dir.
REQ-015 state  out  2  0 HALT, 1 MANUAL, 2 TRACK, 3 SEARCH (for HEX display).

Function
REQ-016 The FSM SHALL start in HALT; desired command in HALT is {STOP, 0}.
REQ-017 In any state, a valid STOP code SHALL enter HALT on the next cycle.
REQ-018 In HALT, only AUTO SHALL leave it (to SEARCH), and a direction code (to MANUAL).
REQ-019 In any state, a valid direction code SHALL enter MANUAL, set desired dir to that code, and reload the hold counter to MANUAL_HOLD.
REQ-020 In MANUAL, desired speed SHALL equal the speed input; when the hold counter reaches 0 the FSM SHALL go to SEARCH.
REQ-021 AUTO while in MANUAL SHALL go to SEARCH immediately.
REQ-022 In SEARCH, desired command SHALL be {SPIN, SEARCH_SPEED}; orange_detected high SHALL enter TRACK.
REQ-023 In TRACK, desired command SHALL be {cam_direction, speed}; cam_direction values above 5 SHALL map to STOP.
REQ-024 In TRACK, the lost counter SHALL reload to LOST_TIMEOUT whenever orange_detected is high and decrement otherwise; on 0 the FSM SHALL go to SEARCH.
REQ-025 IR events SHALL take priority over camera events arriving in the same cycle; STOP outranks other IR codes.
REQ-026 A command SHALL be offered (cmd_valid rises) only when the desired {dir, speed} differs from the last accepted command.
REQ-027 While cmd_valid && !cmd_ready, cmd_dir and cmd_speed SHALL remain stable.
REQ-028 Desired changes during a stall SHALL coalesce: after acceptance, cmd_valid SHALL re-assert next cycle only if the latest desired command differs from the one accepted.
REQ-029 A handshake completing in the same cycle as a desired change SHALL record the offered command as accepted and offer the new one next cycle.
REQ-030 Latency from ir_valid to cmd_valid SHALL be 2 cycles when idle (state update, then offer register).
REQ-031 Counters SHALL saturate at 0 and never wrap.

Reset
REQ-032 Asserting rst_n low SHALL immediately force state=HALT, cmd_valid=0, cmd_dir=0, cmd_speed=0, last-accepted={STOP,0}, counters=0.
REQ-033 Reset mid-handshake SHALL drop the pending command without acceptance.
REQ-034 After reset release no command SHALL be offered until desired differs from {STOP,0}.

Structure
REQ-035 Direction encodings, IR codes and the state enum SHALL live in shared package drive_pkg, reused by the FSM and HEX decoders.
REQ-036 The valid/ready offer register with coalescing SHALL be sub-module cmd_offer_reg; the FSM and counters stay in drive_cmd_arbiter.

Verification (MANUAL_HOLD=20, LOST_TIMEOUT=10)
REQ-037 Reset, ir 8'h01, speed=2, ready=1 -> cmd {1,2} valid 2 cycles later, accepted once; state=MANUAL; 20 cycles later state=SEARCH, cmd {5,1}.
REQ-038 In SEARCH, orange_detected=1, cam_direction=2 -> state=TRACK, cmd {2,speed}; drop orange 10 cycles -> SEARCH, cmd {5,1}.
REQ-039 ready=0, desired changes FWD->LEFT->RIGHT during stall -> FWD held stable; after ready, only RIGHT offered; LEFT never appears.
REQ-040 Same-cycle ir 8'h05 and orange_detected rise in TRACK -> state=HALT, cmd {0,0}.
REQ-041 rst_n low while cmd_valid=1, ready=0 -> cmd_valid=0 immediately; no command after release until IR input.
REQ-042 ir 8'h07 (unknown) in any state -> no state or cmd change.

Source files
------------

// File: rtl/drive_pkg.sv
// rtl/drive_pkg.sv - shared drive encodings: states, directions, IR codes
package drive_pkg;

  typedef enum logic [1:0] {
    ST_HALT   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_TRACK  = 2'd2,
    ST_SEARCH = 2'd3
  } drive_state_e;

  typedef enum logic [2:0] {
    DIR_STOP  = 3'd0,
    DIR_FWD   = 3'd1,
    DIR_LEFT  = 3'd2,
    DIR_RIGHT = 3'd3,
    DIR_REV   = 3'd4,
    DIR_SPIN  = 3'd5
  } drive_dir_e;

  localparam logic [7:0] IR_FWD   = 8'h01;
  localparam logic [7:0] IR_LEFT  = 8'h02;
  localparam logic [7:0] IR_RIGHT = 8'h03;
  localparam logic [7:0] IR_REV   = 8'h04;
  localparam logic [7:0] IR_STOP  = 8'h05;
  localparam logic [7:0] IR_AUTO  = 8'h0A;

  // True for the four IR codes that steer the robot directly.
  function automatic logic is_dir_code(input logic [7:0] code);
    case (code)
      IR_FWD, IR_LEFT, IR_RIGHT, IR_REV: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] ir_to_dir(input logic [7:0] code);
    case (code)
      IR_FWD:   return DIR_FWD;
      IR_LEFT:  return DIR_LEFT;
      IR_RIGHT: return DIR_RIGHT;
      IR_REV:   return DIR_REV;
      default:  return DIR_STOP;
    endcase
  endfunction

  // Camera codes beyond SPIN are not meaningful steering requests; stop instead.
  function automatic logic [2:0] cam_to_dir(input logic [2:0] cam);
    return (cam > 3'd5) ? 3'(DIR_STOP) : cam;
  endfunction

endpackage

// File: rtl/cmd_offer_reg.sv
// rtl/cmd_offer_reg.sv - valid/ready command offer register with stall coalescing
module cmd_offer_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] desired_dir,
  input  logic [1:0] desired_speed,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_dir,
  output logic [1:0] cmd_speed
);

  logic [2:0] last_dir;
  logic [1:0] last_speed;
  logic       differs_offer;
  logic       differs_last;

  assign differs_offer = {desired_dir, desired_speed} != {cmd_dir, cmd_speed};
  assign differs_last  = {desired_dir, desired_speed} != {last_dir, last_speed};

  // Offered command is frozen while stalled; only the newest desired value is offered after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid  <= 1'b0;
      cmd_dir    <= 3'd0;
      cmd_speed  <= 2'd0;
      last_dir   <= 3'd0;
      last_speed <= 2'd0;
    end else if (cmd_valid && cmd_ready) begin
      last_dir   <= cmd_dir;
      last_speed <= cmd_speed;
      if (differs_offer) begin
        cmd_valid <= 1'b1;
        cmd_dir   <= desired_dir;
        cmd_speed <= desired_speed;
      end else begin
        cmd_valid <= 1'b0;
      end
    end else if (!cmd_valid && differs_last) begin
      cmd_valid <= 1'b1;
      cmd_dir   <= desired_dir;
      cmd_speed <= desired_speed;
    end
  end

endmodule

// File: rtl/drive_cmd_arbiter.sv
// rtl/drive_cmd_arbiter.sv - arbitrates IR, camera and search modes into motor commands
module drive_cmd_arbiter #(
  parameter int         MANUAL_HOLD  = 50_000_000,
  parameter int         LOST_TIMEOUT = 12_500_000,
  parameter logic [1:0] SEARCH_SPEED = 2'd1
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic       ir_valid,
  input  logic [7:0] ir_button,
  input  logic [2:0] cam_direction,
  input  logic       orange_detected,
  input  logic [1:0] speed,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_dir,
  output logic [1:0] cmd_speed,
  output logic [1:0] state
);
  import drive_pkg::*;

  localparam int HOLD_W = $clog2(MANUAL_HOLD + 1);
  localparam int LOST_W = $clog2(LOST_TIMEOUT + 1);

  drive_state_e      cur_state;
  logic [2:0]        man_dir;
  logic [HOLD_W-1:0] hold_cnt;
  logic [LOST_W-1:0] lost_cnt;
  logic              ir_stop;
  logic              ir_dir;
  logic              ir_auto;
  logic [2:0]        des_dir;
  logic [1:0]        des_speed;

  // AUTO only means something when not already in an autonomous mode.
  assign ir_stop = ir_valid && (ir_button == IR_STOP);
  assign ir_dir  = ir_valid && is_dir_code(ir_button);
  assign ir_auto = ir_valid && (ir_button == IR_AUTO) &&
                   ((cur_state == ST_HALT) || (cur_state == ST_MANUAL));

  // Mode FSM: STOP beats other IR codes, IR beats camera; counters end their mode on reaching 0.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= ST_HALT;
      man_dir   <= DIR_STOP;
      hold_cnt  <= '0;
      lost_cnt  <= '0;
    end else if (ir_stop) begin
      cur_state <= ST_HALT;
      hold_cnt  <= '0;
      lost_cnt  <= '0;
    end else if (ir_dir) begin
      cur_state <= ST_MANUAL;
      man_dir   <= ir_to_dir(ir_button);
      hold_cnt  <= HOLD_W'(MANUAL_HOLD);
    end else if (ir_auto) begin
      cur_state <= ST_SEARCH;
      hold_cnt  <= '0;
    end else begin
      case (cur_state)
        ST_MANUAL: begin
          if (hold_cnt <= HOLD_W'(1)) begin
            hold_cnt  <= '0;
            cur_state <= ST_SEARCH;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        ST_SEARCH: begin
          if (orange_detected) begin
            cur_state <= ST_TRACK;
            lost_cnt  <= LOST_W'(LOST_TIMEOUT);
          end
        end
        ST_TRACK: begin
          if (orange_detected) begin
            lost_cnt <= LOST_W'(LOST_TIMEOUT);
          end else if (lost_cnt <= LOST_W'(1)) begin
            lost_cnt  <= '0;
            cur_state <= ST_SEARCH;
          end else begin
            lost_cnt <= lost_cnt - LOST_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Desired command follows the current mode; the offer register decides when to present it.
  always_comb begin
    des_dir   = DIR_STOP;
    des_speed = 2'd0;
    case (cur_state)
      ST_MANUAL: begin
        des_dir   = man_dir;
        des_speed = speed;
      end
      ST_TRACK: begin
        des_dir   = cam_to_dir(cam_direction);
        des_speed = speed;
      end
      ST_SEARCH: begin
        des_dir   = DIR_SPIN;
        des_speed = SEARCH_SPEED;
      end
      default: ;
    endcase
  end

  assign state = cur_state;

  cmd_offer_reg u_offer (
    .clk          (clk_50),
    .rst_n        (rst_n),
    .desired_dir  (des_dir),
    .desired_speed(des_speed),
    .cmd_ready    (cmd_ready),
    .cmd_valid    (cmd_valid),
    .cmd_dir      (cmd_dir),
    .cmd_speed    (cmd_speed)
  );

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// tb/tb_drive_cmd_arbiter.sv - directed self-checking bench for drive_cmd_arbiter
module tb_drive_cmd_arbiter;

  logic       clk_50 = 1'b0;
  logic       rst_n;
  logic       ir_valid;
  logic [7:0] ir_button;
  logic [2:0] cam_direction;
  logic       orange_detected;
  logic [1:0] speed;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_dir;
  logic [1:0] cmd_speed;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_count = 0;
  int left_seen = 0;

  drive_cmd_arbiter #(
    .MANUAL_HOLD (20),
    .LOST_TIMEOUT(10),
    .SEARCH_SPEED(2'd1)
  ) dut (
    .clk_50         (clk_50),
    .rst_n          (rst_n),
    .ir_valid       (ir_valid),
    .ir_button      (ir_button),
    .cam_direction  (cam_direction),
    .orange_detected(orange_detected),
    .speed          (speed),
    .cmd_ready      (cmd_ready),
    .cmd_valid      (cmd_valid),
    .cmd_dir        (cmd_dir),
    .cmd_speed      (cmd_speed),
    .state          (state)
  );

  always #5 clk_50 = ~clk_50;

  // Handshake log
  always @(posedge clk_50) begin
    if (rst_n && cmd_valid && cmd_ready) begin
      hs_count = hs_count + 1;
      if (cmd_dir == 3'd2) left_seen = left_seen + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_50);
      #1;
    end
  endtask

  task automatic ir_pulse(input logic [7:0] code);
    ir_valid  = 1'b1;
    ir_button = code;
    tick();
    ir_valid  = 1'b0;
    ir_button = 8'h00;
  endtask

  task automatic check_cmd(input string tag, input logic v, input logic [2:0] d, input logic [1:0] s);
    check({tag, "_valid"}, 32'(cmd_valid), 32'(v));
    check({tag, "_dir"},   32'(cmd_dir),   32'(d));
    check({tag, "_speed"}, 32'(cmd_speed), 32'(s));
  endtask

  initial begin
    rst_n = 1'b0;
    ir_valid = 1'b0;
    ir_button = 8'h00;
    cam_direction = 3'd0;
    orange_detected = 1'b0;
    speed = 2'd2;
    cmd_ready = 1'b1;
    tick(2);
    check("reset_state", 32'(state), 32'd0);
    check_cmd("reset", 1'b0, 3'd0, 2'd0);
    rst_n = 1'b1;
    tick(3);
    check_cmd("idle_after_reset", 1'b0, 3'd0, 2'd0);

    // manual FWD, 2-cycle latency, single acceptance, hold timeout
    hs_count = 0;
    ir_pulse(8'h01);
    check("man_state", 32'(state), 32'd1);
    check("man_lat1_valid", 32'(cmd_valid), 32'd0);
    tick();
    check_cmd("man_offer", 1'b1, 3'd1, 2'd2);
    tick();
    check("man_accepted_valid", 32'(cmd_valid), 32'd0);
    tick(17);
    check("man_hold_19", 32'(state), 32'd1);
    check("man_hs_once", 32'(hs_count), 32'd1);
    tick();
    check("man_to_search", 32'(state), 32'd3);
    tick();
    check_cmd("search_offer", 1'b1, 3'd5, 2'd1);
    tick();

    // track, out-of-range camera code, lost timeout
    orange_detected = 1'b1;
    cam_direction = 3'd2;
    tick();
    check("track_state", 32'(state), 32'd2);
    tick();
    check_cmd("track_offer", 1'b1, 3'd2, 2'd2);
    tick();
    cam_direction = 3'd6;
    tick();
    check_cmd("track_cam6", 1'b1, 3'd0, 2'd2);
    tick();
    orange_detected = 1'b0;
    tick(9);
    check("lost_9", 32'(state), 32'd2);
    tick();
    check("lost_to_search", 32'(state), 32'd3);
    tick();
    check_cmd("lost_search_offer", 1'b1, 3'd5, 2'd1);
    tick();

    // stall coalescing FWD -> LEFT -> RIGHT
    hs_count = 0;
    left_seen = 0;
    cmd_ready = 1'b0;
    ir_pulse(8'h01);
    tick();
    check_cmd("stall_offer", 1'b1, 3'd1, 2'd2);
    ir_pulse(8'h02);
    check_cmd("stall_hold1", 1'b1, 3'd1, 2'd2);
    ir_pulse(8'h03);
    check_cmd("stall_hold2", 1'b1, 3'd1, 2'd2);
    tick();
    check_cmd("stall_hold3", 1'b1, 3'd1, 2'd2);
    cmd_ready = 1'b1;
    tick();
    check_cmd("coalesce_right", 1'b1, 3'd3, 2'd2);
    tick();
    check("coalesce_done", 32'(cmd_valid), 32'd0);
    check("coalesce_hs", 32'(hs_count), 32'd2);
    check("left_never", 32'(left_seen), 32'd0);

    // AUTO from MANUAL, then STOP racing orange in TRACK
    ir_pulse(8'h0A);
    check("auto_to_search", 32'(state), 32'd3);
    tick(2);
    orange_detected = 1'b1;
    cam_direction = 3'd2;
    tick();
    check("track2_state", 32'(state), 32'd2);
    tick(2);
    orange_detected = 1'b0;
    tick();
    orange_detected = 1'b1;
    ir_pulse(8'h05);
    check("stop_beats_cam", 32'(state), 32'd0);
    tick();
    check_cmd("halt_offer", 1'b1, 3'd0, 2'd0);
    tick();

    // unknown code ignored in HALT and MANUAL; camera ignored in HALT
    ir_pulse(8'h07);
    check("unk_halt_state", 32'(state), 32'd0);
    tick();
    check("unk_halt_valid", 32'(cmd_valid), 32'd0);
    orange_detected = 1'b0;
    ir_pulse(8'h01);
    tick(2);
    ir_pulse(8'h07);
    check("unk_man_state", 32'(state), 32'd1);
    tick();
    check_cmd("unk_man_cmd", 1'b0, 3'd1, 2'd2);

    // reset mid-stall drops the offer; nothing offered until new IR
    cmd_ready = 1'b0;
    ir_pulse(8'h04);
    tick();
    check_cmd("rst_pre", 1'b1, 3'd4, 2'd2);
    rst_n = 1'b0;
    #1;
    check_cmd("rst_async", 1'b0, 3'd0, 2'd0);
    check("rst_async_state", 32'(state), 32'd0);
    tick();
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    hs_count = 0;
    tick(4);
    check("rst_quiet_valid", 32'(cmd_valid), 32'd0);
    check("rst_quiet_hs", 32'(hs_count), 32'd0);
    ir_pulse(8'h01);
    tick();
    check_cmd("rst_resume", 1'b1, 3'd1, 2'd2);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
